// File: rtl/fp_addsub_sequencer_pkg.sv
// Shared types and constants for the FP add/sub sequencer.
//   - state_e      : sequencer FSM states
//   - QNAN         : canonical quiet NaN returned when an operand exponent is all ones
//   - EXP_*/SIGN_* : IEEE-754 single-precision field positions
//   - exp_abs_diff : unsigned 8-bit |ea - eb|
package fp_addsub_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StSettle,
      StResp
   } state_e;

   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam int unsigned EXP_MSB  = 30;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned SIGN_BIT = 31;
   localparam logic [7:0]  EXP_INF  = 8'hFF;

   function automatic logic [7:0] exp_abs_diff(input logic [7:0] ea, input logic [7:0] eb);
      return (ea >= eb) ? (ea - eb) : (eb - ea);
   endfunction

endpackage

// File: rtl/fp_addsub_sequencer_arb.sv
// Two-way round-robin arbiter for the FP add/sub sequencer.
//   i_clk, i_reset : clock, asynchronous active-high reset (pointer -> 0, requester 0 preferred)
//   i_valid[1:0]   : requester valids
//   i_done         : operation completed this cycle (response handed off)
//   i_done_id      : requester that owned the completed operation
//   o_grant[1:0]   : one-hot grant (zero when nobody is valid)
module fp_addsub_sequencer_arb (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_valid,
   input  logic       i_done,
   input  logic       i_done_id,
   output logic [1:0] o_grant
);

   logic r_ptr;

   // The requester that was just served loses priority.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ptr <= 1'b0;
      end else if (i_done) begin
         r_ptr <= ~i_done_id;
      end
   end

   always_comb begin
      o_grant = i_valid;
      if (&i_valid) begin
         o_grant = r_ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// Sequencer for one shared serial-alignment FP add/sub datapath serving two requesters.
//   i_clk, i_reset            : clock, asynchronous active-high reset
//   i_reqN_valid/o_reqN_ready : request handshake (ready only in IDLE, only for the granted side)
//   i_reqN_a/b, i_reqN_op     : single-precision operands, op 0=add 1=sub
//   o_rsp_valid/i_rsp_ready   : response handshake, o_rsp_data/id/exc held until accepted
//   o_dp_a/b, o_dp_clr/load   : datapath operands (b sign flipped for sub), clear and load strobes
//   i_dp_result               : datapath output, sampled at the end of the last settle cycle
//   o_busy                    : FSM not in IDLE
module fp_addsub_sequencer
   import fp_addsub_sequencer_pkg::*;
#(
   parameter int unsigned MAX_SHIFT  = 24,
   parameter int unsigned SETTLE_CYC = 1,
   parameter int unsigned CNT_W      = 5
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [31:0] i_req0_a,
   input  logic [31:0] i_req0_b,
   input  logic        i_req0_op,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [31:0] i_req1_a,
   input  logic [31:0] i_req1_b,
   input  logic        i_req1_op,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_data,
   output logic        o_rsp_id,
   output logic        o_rsp_exc,
   output logic [31:0] o_dp_a,
   output logic [31:0] o_dp_b,
   output logic        o_dp_clr,
   output logic        o_dp_load,
   input  logic [31:0] i_dp_result,
   output logic        o_busy
);

   localparam logic [7:0]       MaxShift8 = 8'(MAX_SHIFT);
   localparam logic [CNT_W-1:0] MaxShiftC = CNT_W'(MAX_SHIFT);
   localparam logic [CNT_W-1:0] SettleC   = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic             r_id;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_exc;

   logic [1:0]       w_grant;
   logic             w_accept;
   logic             w_done;
   logic [31:0]      w_sel_a;
   logic [31:0]      w_sel_b;
   logic [7:0]       w_exp_a;
   logic [7:0]       w_exp_b;
   logic [7:0]       w_diff;
   logic [CNT_W-1:0] w_shift;
   logic             w_bypass;

   fp_addsub_sequencer_arb u_arb (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_valid   ({i_req1_valid, i_req0_valid}),
      .i_done    (w_done),
      .i_done_id (r_id),
      .o_grant   (w_grant)
   );

   // Accept is combinational in IDLE; gated by reset so every output is 0 while reset is held.
   assign w_accept = (r_state == StIdle) && (|w_grant) && !i_reset;
   assign w_done   = (r_state == StResp) && i_rsp_ready;

   always_comb begin
      w_sel_a           = w_grant[1] ? i_req1_a : i_req0_a;
      w_sel_b           = w_grant[1] ? i_req1_b : i_req0_b;
      w_sel_b[SIGN_BIT] = w_sel_b[SIGN_BIT] ^ (w_grant[1] ? i_req1_op : i_req0_op);
   end

   assign w_exp_a  = r_a[EXP_MSB:EXP_LSB];
   assign w_exp_b  = r_b[EXP_MSB:EXP_LSB];
   assign w_diff   = exp_abs_diff(w_exp_a, w_exp_b);
   assign w_shift  = (w_diff > MaxShift8) ? MaxShiftC : w_diff[CNT_W-1:0];
   assign w_bypass = (w_exp_a == EXP_INF) || (w_exp_b == EXP_INF);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_id        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_exc   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_a     <= w_sel_a;
                  r_b     <= w_sel_b;
                  r_id    <= w_grant[1];
                  r_state <= StLoad;
               end
            end
            StLoad: begin
               if (w_bypass) begin
                  r_rsp_data  <= QNAN;
                  r_rsp_exc   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StResp;
               end else if (w_diff == 8'd0) begin
                  r_cnt   <= SettleC;
                  r_state <= StSettle;
               end else begin
                  r_cnt   <= w_shift;
                  r_state <= StShift;
               end
            end
            StShift: begin
               if (r_cnt == CntOne) begin
                  r_cnt   <= SettleC;
                  r_state <= StSettle;
               end else begin
                  r_cnt <= r_cnt - CntOne;
               end
            end
            StSettle: begin
               if (r_cnt == CntOne) begin
                  r_rsp_data  <= i_dp_result;
                  r_rsp_exc   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StResp;
               end else begin
                  r_cnt <= r_cnt - CntOne;
               end
            end
            StResp: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_exc   <= 1'b0;
                  r_a         <= '0;
                  r_b         <= '0;
                  r_id        <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req0_ready = w_accept && w_grant[0];
   assign o_req1_ready = w_accept && w_grant[1];
   assign o_dp_clr     = w_accept;
   assign o_dp_load    = (r_state == StLoad);
   assign o_dp_a       = r_a;
   assign o_dp_b       = r_b;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_data   = r_rsp_data;
   assign o_rsp_id     = r_id;
   assign o_rsp_exc    = r_rsp_exc;
   assign o_busy       = (r_state != StIdle);

endmodule
